muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 32 bits.
REQ-002 Port Clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 Port Reset, input, 1: asynchronous, active-high reset.
REQ-004 Port Start, input, 1: request to begin an operation; sampled on the rising edge of Clk.
REQ-005 Port Op, input, 2: operation select; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled together with Start.
REQ-006 Port A, input, 32: multiplicand or dividend (register A output); sampled together with Start.
REQ-007 Port B, input, 32: multiplier or divisor (register B output); sampled together with Start.
REQ-008 Port Busy, output, 1: high while an operation is in progress.
REQ-009 Port Done, output, 1: one-cycle pulse; Hi and Lo hold a valid result during this cycle.
REQ-010 Port Hi, output, 32: product high word, or remainder.
REQ-011 Port Lo, output, 32: product low word, or quotient.
REQ-012 Port DivZero, output, 1: high together with Done when a divide by zero occurred; held until the next accepted Start.

Function
REQ-013 The state machine SHALL have the states IDLE, CALC, FIX and DONE.
REQ-014 IDLE and DONE: Start=1 SHALL latch Op, A and B and move to CALC; DivZero SHALL clear on the same edge.
REQ-015 DONE with Start=0 SHALL move to IDLE.
REQ-016 CALC SHALL run exactly 32 iterations counted by a 5-bit counter (0..31, no wrap), then move to FIX.
REQ-017 Multiply iteration: radix-2 shift-add on the operand magnitudes, 64-bit accumulator.
REQ-018 Divide iteration: radix-2 restoring divide on the magnitudes; one quotient bit per cycle.
REQ-019 FIX SHALL apply sign correction and write Hi/Lo, then move to DONE.
REQ-020 Latency: Done SHALL be high in exactly the 34th cycle after the Start-accept edge.
REQ-021 Busy SHALL be 1 in CALC and FIX and 0 in IDLE and DONE; Done SHALL be 1 only in DONE.
REQ-022 Start while Busy=1 SHALL be ignored; Op, A and B changes SHALL have no effect after acceptance.
REQ-023 MULT/MULTU SHALL produce the full 64-bit two's-complement or unsigned product as {Hi,Lo}.
REQ-024 Signed DIV SHALL truncate the quotient toward zero; the remainder SHALL take the sign of the dividend.
REQ-025 DIV 0x80000000 / 0xFFFFFFFF SHALL give Lo=0x80000000, Hi=0 with no flag.
REQ-026 Divide with B=0 SHALL skip CALC and FIX: the next edge enters DONE with Hi=A, Lo=0xFFFFFFFF, DivZero=1.
REQ-027 Hi and Lo SHALL hold their last result until the next FIX or divide-by-zero DONE.

Reset
REQ-028 Reset=1 SHALL immediately force IDLE, counter=0, Busy=0, Done=0, DivZero=0, Hi=0, Lo=0 and the internal accumulators to 0.
REQ-029 Reset asserted mid-operation SHALL abandon the operation; no Done pulse SHALL follow.
REQ-030 The first Start SHALL be accepted on the first rising edge after Reset deasserts.

Configuration
REQ-031 With MULDIV_SIGNED_EN defined, MULT and DIV SHALL be signed as specified above.
REQ-032 Without MULDIV_SIGNED_EN, Op[0] SHALL be ignored; MULT behaves as MULTU and DIV as DIVU.
REQ-033 Without MULDIV_SIGNED_EN, no sign-correction logic SHALL exist, but FIX is still present so latency stays 34.

Verification
REQ-034 Test MULTU, A=B=0xFFFFFFFF: Done in cycle 34 with Hi=0xFFFFFFFE, Lo=0x00000001.
REQ-035 Test MULT, A=0xFFFFFFFD (-3), B=7: Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; with the macro undefined: Hi=0x00000006, Lo=0xFFFFFFEB.
REQ-036 Test DIV, A=0xFFFFFFF9 (-7), B=2: Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
REQ-037 Test DIVU, A=5, B=0: next cycle Done=1, DivZero=1, Hi=5, Lo=0xFFFFFFFF, Busy never 1.
REQ-038 Test Start pulsed at cycle 10 of a MULTU 3*4: ignored; Done at cycle 34 with Lo=12, Hi=0.
REQ-039 Test Reset at cycle 20 of an operation: outputs zero immediately, no Done; a new DIVU 100/7 then gives Lo=14, Hi=2.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply / 32/32 divide unit (MULT, MULTU, DIV, DIVU).
// Latency: Done pulses in the 34th cycle after the Start-accept edge; divide by zero
//   answers on the next cycle. Start is ignored while Busy=1 (no other backpressure).
// Ports:
//   Clk, Reset          clock, asynchronous active-high reset
//   Start, Op[1:0], A, B request and operands (Op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   Busy, Done          operation in progress / one-cycle result-valid pulse
//   Hi, Lo              product {Hi,Lo}, or remainder (Hi) and quotient (Lo)
//   DivZero             divide-by-zero flag, held until the next accepted Start
// Build option: define MULDIV_SIGNED_EN to enable signed MULT/DIV. Without it Op[0]
//   is ignored and every operation is unsigned.
module muldiv_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        DivZero
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q, acc_d;   // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [31:0] opnd_q;         // multiplicand or divisor magnitude
  logic        is_div_q;

  logic [31:0] a_mag, b_mag;
  logic [31:0] fix_hi, fix_lo;
  logic        accept;
  logic        div_by_zero;

  // Operand magnitudes; the iteration itself is always unsigned.
`ifdef MULDIV_SIGNED_EN
  logic is_signed, sgn_a, sgn_b;
  logic neg_prod_q;            // result (product or quotient) needs negation
  logic neg_rem_q;             // remainder needs negation (sign of dividend)

  always_comb begin
    is_signed = ~Op[0];
    sgn_a     = is_signed & A[31];
    sgn_b     = is_signed & B[31];
    a_mag     = sgn_a ? (~A + 32'd1) : A;
    b_mag     = sgn_b ? (~B + 32'd1) : B;
  end
`else
  logic unused_op0;
  assign unused_op0 = Op[0];

  always_comb begin
    a_mag = A;
    b_mag = B;
  end
`endif

  assign accept      = Start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign div_by_zero = Op[1] && (B == 32'd0);

  // One radix-2 iteration of either shift-add multiply or restoring divide.
  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic [32:0] diff;

  always_comb begin
    acc_d  = acc_q;
    sum    = '0;
    rem_sh = '0;
    diff   = '0;
    if (is_div_q) begin
      // Shift the next dividend bit into the remainder and trial-subtract.
      // The remainder is always below the divisor, so the shifted value is
      // below twice the divisor and diff[32] is a true borrow.
      rem_sh = acc_q[63:31];
      diff   = rem_sh - {1'b0, opnd_q};
      if (!diff[32]) begin
        acc_d = {diff[31:0], acc_q[30:0], 1'b1};
      end else begin
        acc_d = {acc_q[62:0], 1'b0};
      end
    end else begin
      // Add multiplicand when the current multiplier LSB is set, then shift
      // the carry back in at the top.
      sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
      acc_d = {sum, acc_q[31:1]};
    end
  end

  // Final result, with sign correction when enabled.
`ifdef MULDIV_SIGNED_EN
  logic [63:0] prod_neg;
  always_comb begin
    prod_neg = 64'd0 - acc_q;
    fix_hi   = acc_q[63:32];
    fix_lo   = acc_q[31:0];
    if (is_div_q) begin
      if (neg_prod_q) fix_lo = 32'd0 - acc_q[31:0];
      if (neg_rem_q)  fix_hi = 32'd0 - acc_q[63:32];
    end else if (neg_prod_q) begin
      fix_hi = prod_neg[63:32];
      fix_lo = prod_neg[31:0];
    end
  end
`else
  always_comb begin
    fix_hi = acc_q[63:32];
    fix_lo = acc_q[31:0];
  end
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      acc_q      <= 64'd0;
      opnd_q     <= 32'd0;
      is_div_q   <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Hi         <= 32'd0;
      Lo         <= 32'd0;
      DivZero    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_prod_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            DivZero  <= 1'b0;
            is_div_q <= Op[1];
            cnt_q    <= 5'd0;
            if (div_by_zero) begin
              // Skip the datapath entirely; answer on the next cycle.
              state_q <= S_DONE;
              Hi      <= A;
              Lo      <= 32'hFFFF_FFFF;
              DivZero <= 1'b1;
              Done    <= 1'b1;
              Busy    <= 1'b0;
            end else begin
              state_q <= S_CALC;
              Busy    <= 1'b1;
              if (Op[1]) begin
                acc_q  <= {32'd0, a_mag};
                opnd_q <= b_mag;
              end else begin
                acc_q  <= {32'd0, b_mag};
                opnd_q <= a_mag;
              end
`ifdef MULDIV_SIGNED_EN
              neg_prod_q <= sgn_a ^ sgn_b;
              neg_rem_q  <= sgn_a;
`endif
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          if (cnt_q == 5'd31) begin
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        S_FIX: begin
          Hi      <= fix_hi;
          Lo      <= fix_lo;
          Busy    <= 1'b0;
          Done    <= 1'b1;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
